// File: rtl/vdp_host_port.sv
// vdp_host_port: CPU-side port with two-byte command latch, auto-incrementing VRAM address,
// read-ahead buffer and full status register.
module vdp_host_port #(
    parameter int VRAM_SIZE = 16384,
    parameter int NUM_REGS  = 8,
    localparam int ADDR_W   = $clog2(VRAM_SIZE),
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                  pxclk,
    input  logic                  reset,
    input  logic                  wr_tick,
    input  logic                  rd_tick,
    input  logic                  mode,
    input  logic [7:0]            din,
    output logic [7:0]            dout,
    output logic [NUM_REGS*8-1:0] regs_flat,
    input  logic                  frame_tick,
    input  logic                  spr5_tick,
    input  logic [4:0]            spr5_num,
    input  logic                  coll_tick,
    output logic                  irq,
    output logic                  vram_req,
    output logic                  vram_we,
    output logic [ADDR_W-1:0]     vram_addr,
    output logic [7:0]            vram_wdata,
    input  logic                  vram_gnt,
    input  logic [7:0]            vram_rdata,
    output logic                  ovr
);
    logic [7:0]        regs [NUM_REGS];
    logic              toggle;
    logic [7:0]        lo;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        rbuf;
    logic              f, s5, c;
    logic [4:0]        num;
    logic              rd_pend;
    logic [13:0]       full_addr;
    logic [ADDR_W-1:0] new_addr, base;
    logic ctrl_wr, data_wr, data_rd, stat_rd, setup, reg_wr, rd_setup, wr_setup, access, busy, issue;

    assign ctrl_wr   = wr_tick & mode;
    assign data_wr   = wr_tick & ~mode;
    assign data_rd   = rd_tick & ~mode;
    assign stat_rd   = rd_tick & mode;
    assign setup     = ctrl_wr & toggle;
    assign reg_wr    = setup & din[7];
    assign rd_setup  = setup & (din[7:6] == 2'b00);
    assign wr_setup  = setup & (din[7:6] == 2'b01);
    assign full_addr = {din[5:0], lo};
    assign new_addr  = full_addr[ADDR_W-1:0];
    assign base      = rd_setup ? new_addr : addr;
    // read data still in flight counts as busy so rbuf is never overwritten twice
    assign busy      = vram_req | rd_pend;
    assign access    = data_wr | data_rd | rd_setup;
    assign issue     = access & ~busy;
    assign dout      = rd_tick ? (mode ? {f, s5, c, num} : rbuf) : 8'h00;
    assign irq       = f & regs[1][5];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs[g];
    end

    always_ff @(posedge pxclk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
            toggle     <= 1'b0;
            lo         <= 8'h00;
            addr       <= '0;
            rbuf       <= 8'h00;
            f          <= 1'b0;
            s5         <= 1'b0;
            c          <= 1'b0;
            num        <= 5'd0;
            rd_pend    <= 1'b0;
            vram_req   <= 1'b0;
            vram_we    <= 1'b0;
            vram_addr  <= '0;
            vram_wdata <= 8'h00;
            ovr        <= 1'b0;
        end else begin
            toggle <= ctrl_wr ? ~toggle : (rd_tick | wr_tick) ? 1'b0 : toggle;
            if (ctrl_wr & ~toggle) lo <= din;
            if (reg_wr && ({1'b0, din[5:0]} < 7'(NUM_REGS))) regs[din[IDX_W-1:0]] <= lo;
            if (wr_setup) addr <= new_addr;
            if (issue) begin
                vram_req   <= 1'b1;
                vram_we    <= data_wr;
                vram_addr  <= base;
                vram_wdata <= din;
                addr       <= base + ADDR_W'(1);
            end
            if (vram_req & vram_gnt) vram_req <= 1'b0;
            rd_pend <= vram_req & vram_gnt & ~vram_we;
            if (issue & data_wr) rbuf <= din;
            else if (rd_pend) rbuf <= vram_rdata;
            if (access & busy) ovr <= 1'b1;
            // set events win over the clear from a coincident status read
            f  <= frame_tick | (f & ~stat_rd);
            c  <= coll_tick | (c & ~stat_rd);
            s5 <= (spr5_tick & ~s5) | (s5 & ~stat_rd);
            if (spr5_tick & ~s5) num <= spr5_num;
        end
    end
endmodule

// File: doc/vdp_host_port.md
Name: vdp_host_port

Overview:
- Parametrised CPU-side port for the vdp99 family.
- Replaces the fixed 8-register interface and the unbuffered VRAM read path with:
  - a TMS-style two-byte command latch;
  - an auto-incrementing VRAM address;
  - a read-ahead buffer;
  - a full status register (F, 5S, C, 5th sprite number).
- Sits between the bus-tick synchroniser and the VRAM arbiter; the display FSM keeps DMA priority at the arbiter.

Parameters:
- VRAM_SIZE, 16384, bytes of VRAM. ADDR_W = $clog2(VRAM_SIZE), range 10..14.
- NUM_REGS, 8, number of control registers, 8..64. IDX_W = $clog2(NUM_REGS).

Ports:
- pxclk  in  1  sole clock (25 MHz).
- reset  in  1  synchronous, active-high.
- wr_tick  in  1  one-cycle CPU write strobe.
- rd_tick  in  1  one-cycle CPU read strobe. Never coincident with wr_tick.
- mode  in  1  0 = data port, 1 = control/status port. Valid with a tick.
- din  in  8  CPU write data.
- dout  out  8  CPU read data. Valid combinationally during rd_tick, 0 otherwise.
- regs_flat  out  NUM_REGS*8  register r at bits [8r+7:8r].
- frame_tick  in  1  end-of-frame pulse.
- spr5_tick  in  1  fifth-sprite-on-line pulse.
- spr5_num  in  5  sprite number qualifying spr5_tick.
- coll_tick  in  1  sprite-collision pulse.
- irq  out  1  level interrupt = F & regs[1][5].
- vram_req  out  1  VRAM access request.
- vram_we  out  1  1 = write, 0 = read. Stable while vram_req.
- vram_addr  out  ADDR_W  access address. Stable while vram_req.
- vram_wdata  out  8  write data. Stable while vram_req.
- vram_gnt  in  1  one-cycle grant from arbiter.
- vram_rdata  in  8  read data, valid the cycle after vram_gnt.
- ovr  out  1  sticky: data-port access dropped because a request was outstanding.

Behaviour:
- Reset (sync, dominates all other inputs): all regs 0, toggle 0, addr 0, rbuf 0, status 0, vram_req 0, ovr 0. Hence irq 0 and dout 0. A reset mid-request drops the request with no write performed.
- Control write, first byte (toggle=0): latch din into lo; toggle becomes 1.
- Control write, second byte (toggle=1): toggle becomes 0, then:
  - din[7]=1: register write. If din[5:0] < NUM_REGS, regs[din[IDX_W-1:0]] <= lo; otherwise ignored.
  - din[7:6]=01: addr <= {din[5:0],lo} truncated to ADDR_W. Write setup, no VRAM access.
  - din[7:6]=00: addr <= {din[5:0],lo} truncated. Issue a read-ahead of the new addr; addr increments when that request is issued.
- Status read (mode=1 rd_tick):
  - dout = {F, 5S, C, num[4:0]} as held before the edge.
  - Clears toggle, F, 5S and C on that edge; num is kept.
- Data read (mode=0 rd_tick): dout = rbuf. Clears toggle. Issues a read of addr, then addr increments.
- Data write (mode=0 wr_tick): clears toggle. Issues a write of din to addr; rbuf <= din; addr increments.
- Address increment wraps modulo 2^ADDR_W.
- VRAM request timing:
  - vram_req rises the cycle after the tick.
  - It is held until vram_gnt and drops the cycle after vram_gnt.
  - For a read, rbuf loads vram_rdata the cycle after vram_gnt.
- A data-port access or read setup arriving while vram_req=1 (or while read data is pending) is dropped: addr and rbuf are unchanged and ovr is set.
- Status set events; set beats clear when coincident with a status read (the read still returns the old value):
  - frame_tick sets F.
  - coll_tick sets C.
  - spr5_tick with 5S=0 sets 5S and latches num <= spr5_num. When 5S=1, further spr5_tick is ignored.
- irq is registered-free: irq = F & regs[1][5], so it follows immediately.
- Register writes take effect the next cycle on regs_flat.

Test Plan:
- Reset, then ctrl writes 0x E0, 0x81 -> regs_flat[15:8]=0xE0 next cycle. Write with index 0x3F (NUM_REGS=8) -> no register changes.
- Ctrl 0x00, 0x40. Data writes 0x11, 0x22, gnt 3 cycles after each req -> VRAM writes 0x0000=0x11, 0x0001=0x22, addr=0x0002, rbuf=0x22.
- Preload VRAM 0x1234=0xAB, 0x1235=0xCD. Ctrl 0x34, 0x12 -> read-ahead of 0x1234. Data read returns 0xAB, next read 0xCD.
- frame_tick with regs[1][5]=1 -> irq=1. Status read returns 0x80 and irq=0 the next cycle. frame_tick coincident with a status read -> F stays 1.
- spr5_tick num=7, then spr5_tick num=9 -> status returns 0x47. Addr 0x3FFF (VRAM_SIZE=16384) data write -> addr wraps to 0x0000.
- Second data write issued while vram_req=1 (gnt withheld) -> ovr=1, only the first write is performed, addr advanced by 1.
